// File: rtl/tile_dispatcher_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tile_dispatcher_pkg
// Brief    : Shared tile geometry, bank-status and read-FSM encodings.
// Revision : 1.0
// ============================================================================
package tile_dispatcher_pkg;

    localparam int unsigned c_TILE_WIDTH = 16;
    localparam int unsigned c_N          = c_TILE_WIDTH * c_TILE_WIDTH;

    localparam logic [1:0] c_BANK_EMPTY   = 2'b00;
    localparam logic [1:0] c_BANK_FULL    = 2'b01;
    localparam logic [1:0] c_BANK_DECIDED = 2'b10;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tile_dispatcher_bank_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tile_bank_ram
// Brief    : One tile bank: DEPTH x DATA_W RAM, one write port, one
//            registered read port whose output holds while iRdEn is low.
// Revision : 1.0
// ============================================================================
module tile_bank_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iWrEn,
    input  logic [AW-1:0]     iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iRdEn,
    input  logic [AW-1:0]     iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge iClk) begin
        if (iWrEn) begin
            r_mem[iWrAddr] <= iWrData;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_rd_data <= '0;
        end else if (iRdEn) begin
            r_rd_data <= r_mem[iRdAddr];
        end
    end

    assign oRdData = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/tile_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tile_dispatcher
// Brief    : Ping-pong tile buffer that pairs each tile with its route
//            decision and streams it to the CNN or SNN port.
//            Optional macro TILE_DISPATCH_STATS_EN adds per-port tile counters.
// Revision : 1.0
// ============================================================================
module tile_dispatcher
    import tile_dispatcher_pkg::*;
#(
    parameter int unsigned TILE_WIDTH = c_TILE_WIDTH,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oInReady,
    input  logic              iRouteToCnn,
    input  logic              iDecisionValid,
    output logic [DATA_W-1:0] oCnnData,
    output logic              oCnnValid,
    output logic              oCnnLast,
    input  logic              iCnnReady,
    output logic [DATA_W-1:0] oSnnData,
    output logic              oSnnValid,
    output logic              oSnnLast,
    input  logic              iSnnReady,
    output logic              oOverflow,
`ifdef TILE_DISPATCH_STATS_EN
    output logic              oProtoErr,
    output logic [15:0]       oCnnTileCnt,
    output logic [15:0]       oSnnTileCnt
`else
    output logic              oProtoErr
`endif
);

    localparam int unsigned   c_NPIX      = TILE_WIDTH * TILE_WIDTH;
    localparam int unsigned   c_AW        = $clog2(c_NPIX);
    localparam logic [c_AW:0] c_NPIX_W    = (c_AW+1)'(c_NPIX);
    localparam logic [c_AW-1:0] c_LAST_ADR = c_AW'(c_NPIX - 1);

    logic [1:0]        w_status  [2];
    logic              w_route   [2];
    logic [DATA_W-1:0] w_rd_data [2];

    logic              r_wr_bank, r_dec_bank, r_rd_bank;
    logic [c_AW-1:0]   r_wr_addr;
    logic [0:0]        r_state, w_state_nxt;
    logic              r_cur_route;
    logic [c_AW:0]     r_issue_cnt;
    logic              r_out_valid, r_out_last;
    logic              r_overflow, r_proto_err;

    logic w_in_ready, w_wr_acc, w_wr_done, w_dec_ok;
    logic w_sel_ready, w_xfer, w_drain_done, w_start, w_rd_en;

    assign w_in_ready   = (w_status[r_wr_bank] == c_BANK_EMPTY);
    assign w_wr_acc     = iValid && w_in_ready;
    assign w_wr_done    = w_wr_acc && (r_wr_addr == c_LAST_ADR);
    // Status is the registered value, so a decision landing on the final write is rejected.
    assign w_dec_ok     = iDecisionValid && (w_status[r_dec_bank] == c_BANK_FULL);
    assign w_sel_ready  = r_cur_route ? iCnnReady : iSnnReady;
    assign w_xfer       = r_out_valid && w_sel_ready;
    assign w_drain_done = (r_state == c_ST_DRAIN) && w_xfer && r_out_last;
    assign w_start      = (r_state == c_ST_IDLE) && (w_status[r_rd_bank] == c_BANK_DECIDED);
    assign w_rd_en      = (r_state == c_ST_DRAIN) && (!r_out_valid || w_sel_ready)
                          && (r_issue_cnt < c_NPIX_W);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [1:0] r_status;
            logic       r_route;

            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    r_status <= c_BANK_EMPTY;
                    r_route  <= 1'b0;
                end else begin
                    if (w_wr_done && (r_wr_bank == 1'(gi))) begin
                        r_status <= c_BANK_FULL;
                    end
                    if (w_dec_ok && (r_dec_bank == 1'(gi))) begin
                        r_status <= c_BANK_DECIDED;
                        r_route  <= iRouteToCnn;
                    end
                    if (w_drain_done && (r_rd_bank == 1'(gi))) begin
                        r_status <= c_BANK_EMPTY;
                    end
                end
            end

            assign w_status[gi] = r_status;
            assign w_route[gi]  = r_route;

            tile_bank_ram #(
                .DEPTH  (c_NPIX),
                .DATA_W (DATA_W),
                .AW     (c_AW)
            ) u_ram (
                .iClk    (iClk),
                .iRst    (iRst),
                .iWrEn   (w_wr_acc && (r_wr_bank == 1'(gi))),
                .iWrAddr (r_wr_addr),
                .iWrData (iData),
                .iRdEn   (w_rd_en && (r_rd_bank == 1'(gi))),
                .iRdAddr (r_issue_cnt[c_AW-1:0]),
                .oRdData (w_rd_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_wr_bank   <= 1'b0;
            r_wr_addr   <= '0;
            r_dec_bank  <= 1'b0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_addr <= w_wr_done ? '0 : r_wr_addr + c_AW'(1);
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (iValid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_dec_ok) begin
                r_dec_bank <= ~r_dec_bank;
            end else if (iDecisionValid) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start)      w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_drain_done) w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state     <= c_ST_IDLE;
            r_rd_bank   <= 1'b0;
            r_cur_route <= 1'b0;
            r_issue_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cur_route <= w_route[r_rd_bank];
                r_issue_cnt <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_drain_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_rd_bank   <= ~r_rd_bank;
            end else if (w_rd_en) begin
                // RAM output register doubles as the output stage; it only advances on a free slot.
                r_issue_cnt <= r_issue_cnt + (c_AW+1)'(1);
                r_out_valid <= 1'b1;
                r_out_last  <= (r_issue_cnt[c_AW-1:0] == c_LAST_ADR);
            end
        end
    end

    assign oInReady  = w_in_ready;
    assign oCnnValid = r_out_valid && r_cur_route;
    assign oSnnValid = r_out_valid && !r_cur_route;
    assign oCnnLast  = oCnnValid && r_out_last;
    assign oSnnLast  = oSnnValid && r_out_last;
    assign oCnnData  = oCnnValid ? w_rd_data[r_rd_bank] : '0;
    assign oSnnData  = oSnnValid ? w_rd_data[r_rd_bank] : '0;
    assign oOverflow = r_overflow;
    assign oProtoErr = r_proto_err;

`ifdef TILE_DISPATCH_STATS_EN
    logic [15:0] r_cnn_cnt, r_snn_cnt;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_cnn_cnt <= '0;
            r_snn_cnt <= '0;
        end else if (w_drain_done) begin
            if (r_cur_route) r_cnn_cnt <= r_cnn_cnt + 16'd1;
            else             r_snn_cnt <= r_snn_cnt + 16'd1;
        end
    end

    assign oCnnTileCnt = r_cnn_cnt;
    assign oSnnTileCnt = r_snn_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tile_dispatcher
// Brief    : Scoreboard bench for tile_dispatcher with directed tiles.
// Revision : 1.0
// ============================================================================
module tb_tile_dispatcher;
    import tile_dispatcher_pkg::*;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic [7:0] iData = '0;
    logic       iValid = 1'b0;
    logic       oInReady;
    logic       iRouteToCnn = 1'b0;
    logic       iDecisionValid = 1'b0;
    logic [7:0] oCnnData, oSnnData;
    logic       oCnnValid, oCnnLast, oSnnValid, oSnnLast;
    logic       iCnnReady;
    logic       iSnnReady = 1'b1;
    logic       oOverflow, oProtoErr;
`ifdef TILE_DISPATCH_STATS_EN
    logic [15:0] oCnnTileCnt, oSnnTileCnt;
`endif

    tile_dispatcher u_dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iData          (iData),
        .iValid         (iValid),
        .oInReady       (oInReady),
        .iRouteToCnn    (iRouteToCnn),
        .iDecisionValid (iDecisionValid),
        .oCnnData       (oCnnData),
        .oCnnValid      (oCnnValid),
        .oCnnLast       (oCnnLast),
        .iCnnReady      (iCnnReady),
        .oSnnData       (oSnnData),
        .oSnnValid      (oSnnValid),
        .oSnnLast       (oSnnLast),
        .iSnnReady      (iSnnReady),
        .oOverflow      (oOverflow),
`ifdef TILE_DISPATCH_STATS_EN
        .oProtoErr      (oProtoErr),
        .oCnnTileCnt    (oCnnTileCnt),
        .oSnnTileCnt    (oSnnTileCnt)
`else
        .oProtoErr      (oProtoErr)
`endif
    );

    always #5 iClk = ~iClk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] q_cnn[$];
    logic [8:0] q_snn[$];
    int         pend[$];
    int         cyc = 0;
    logic       toggle_en = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;

    always @(posedge iClk) begin
        cyc++;
        #1;
        iCnnReady = toggle_en ? rdy_pat[cyc[1:0]] : 1'b1;
    end

    function automatic logic [7:0] pix(int pat, int i);
        int t;
        case (pat)
            0:       t = i;
            1:       t = i * 3;
            2:       t = 255 - i;
            3:       t = i ^ 32'h5A;
            4:       t = i + 32'h40;
            default: t = i * 7;
        endcase
        return t[7:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    logic       r_stall = 1'b0;
    logic [7:0] r_stall_d = '0;
    always @(negedge iClk) begin
        logic [8:0] e;
        if (oCnnValid) begin
            if (q_cnn.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL cnn_unexpected: got valid data %0h, expected no traffic", oCnnData);
            end else if (iCnnReady) begin
                e = q_cnn.pop_front();
                chk("cnn_pixel", {23'd0, oCnnLast, oCnnData}, {23'd0, e});
            end
        end
        if (oSnnValid) begin
            if (q_snn.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL snn_unexpected: got valid data %0h, expected no traffic", oSnnData);
            end else if (iSnnReady) begin
                e = q_snn.pop_front();
                chk("snn_pixel", {23'd0, oSnnLast, oSnnData}, {23'd0, e});
            end
        end
        if (r_stall && iRst)
            chk("cnn_hold", {23'd0, oCnnValid, oCnnData}, {23'd0, 1'b1, r_stall_d});
        r_stall   = oCnnValid && !iCnnReady && iRst;
        r_stall_d = oCnnData;
    end

    task automatic send_tile(int pat, bit dec_at_end, output int lows);
        lows = 0;
        for (int i = 0; i < c_N; i++) begin
            @(posedge iClk); #1;
            iValid         = 1'b1;
            iData          = pix(pat, i);
            iRouteToCnn    = 1'b1;
            iDecisionValid = dec_at_end && (i == c_N - 1);
            if (!oInReady) lows++;
        end
        @(posedge iClk); #1;
        iValid = 1'b0;
        iDecisionValid = 1'b0;
    endtask

    task automatic decide(bit route);
        int pat;
        pat = pend.pop_front();
        @(posedge iClk); #1;
        iDecisionValid = 1'b1;
        iRouteToCnn    = route;
        for (int i = 0; i < c_N; i++) begin
            if (route) q_cnn.push_back({i == c_N - 1, pix(pat, i)});
            else       q_snn.push_back({i == c_N - 1, pix(pat, i)});
        end
        @(posedge iClk); #1;
        iDecisionValid = 1'b0;
    endtask

    task automatic wait_empty(string name);
        int n;
        n = 0;
        while ((q_cnn.size() != 0 || q_snn.size() != 0) && n < 3000) begin
            @(negedge iClk);
            n++;
        end
        chk(name, q_cnn.size() + q_snn.size(), 0);
        repeat (4) @(negedge iClk);
    endtask

    task automatic chk_outs_zero(string name);
        chk(name, {10'd0, oCnnValid, oCnnLast, oCnnData, oSnnValid, oSnnLast, oSnnData,
                   oOverflow, oProtoErr}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge iClk); #2;
        iRst = 1'b0;
        #1;
        chk_outs_zero("reset_outputs_zero");
        q_cnn.delete();
        q_snn.delete();
        pend.delete();
        repeat (2) @(posedge iClk);
        #3;
        iRst = 1'b1;
    endtask

    initial begin
        int la, lb;
        int n;
        repeat (3) @(posedge iClk);
        #3;
        chk_outs_zero("reset_outputs");
`ifdef TILE_DISPATCH_STATS_EN
        chk("reset_counters", {oCnnTileCnt, oSnnTileCnt}, 32'd0);
`endif
        iRst = 1'b1;
        @(negedge iClk);
        chk("in_ready_after_reset", {31'd0, oInReady}, 32'd1);

        // Single tile to CNN with latency check
        send_tile(0, 1'b0, la);
        chk("t1_ready_lows", la, 0);
        pend.push_back(0);
        repeat (257) @(posedge iClk);
        decide(1'b1);
        @(negedge iClk); chk("lat_t1", {31'd0, oCnnValid}, 32'd0);
        @(negedge iClk); chk("lat_t2", {31'd0, oCnnValid}, 32'd0);
        @(negedge iClk); chk("lat_t3", {31'd0, oCnnValid}, 32'd1);
        wait_empty("t1_drain");

        // Back-to-back tiles, SNN then CNN
        send_tile(1, 1'b0, la); pend.push_back(1);
        send_tile(2, 1'b0, lb); pend.push_back(2);
        chk("b2b_ready_lows", la + lb, 0);
        decide(1'b0);
        decide(1'b1);
        wait_empty("b2b_drain");
        chk("no_overflow_yet", {31'd0, oOverflow}, 32'd0);
        chk("no_protoerr_yet", {31'd0, oProtoErr}, 32'd0);

        // Both banks full: third tile dropped; then drain with CNN back-pressure
        send_tile(3, 1'b0, la); pend.push_back(3);
        send_tile(5, 1'b0, lb); pend.push_back(5);
        chk("full_fill_ready_lows", la + lb, 0);
        send_tile(4, 1'b0, la);
        chk("dropped_tile_ready_lows", la, c_N);
        chk("overflow_set", {31'd0, oOverflow}, 32'd1);
        toggle_en = 1'b1;
        decide(1'b1);
        decide(1'b0);
        wait_empty("backpressure_drain");
        toggle_en = 1'b0;

        // Decision with no full bank
        @(posedge iClk); #1;
        iDecisionValid = 1'b1; iRouteToCnn = 1'b1;
        @(posedge iClk); #1;
        iDecisionValid = 1'b0;
        @(negedge iClk);
        chk("protoerr_no_full_bank", {31'd0, oProtoErr}, 32'd1);
        repeat (10) @(negedge iClk);

        // Decision coincident with final write is rejected; a later one works
        pulse_reset();
        send_tile(0, 1'b1, la);
        @(negedge iClk);
        chk("protoerr_coincident", {31'd0, oProtoErr}, 32'd1);
        repeat (20) @(negedge iClk);
        pend.push_back(0);
        decide(1'b0);
        wait_empty("late_decision_drain");

        // Reset mid-drain, then a clean tile
        pulse_reset();
        send_tile(1, 1'b0, la); pend.push_back(1);
        decide(1'b1);
        n = 0;
        while (q_cnn.size() > c_N - 100 && n < 2000) begin
            @(negedge iClk);
            n++;
        end
        chk("mid_drain_reached", {31'd0, q_cnn.size() == c_N - 100}, 32'd1);
        pulse_reset();
`ifdef TILE_DISPATCH_STATS_EN
        chk("counters_after_reset", {oCnnTileCnt, oSnnTileCnt}, 32'd0);
`endif
        repeat (20) @(negedge iClk);
        send_tile(2, 1'b0, la); pend.push_back(2);
        chk("post_reset_ready_lows", la, 0);
        decide(1'b1);
        wait_empty("post_reset_drain");
`ifdef TILE_DISPATCH_STATS_EN
        chk("counters_after_tile", {oCnnTileCnt, oSnnTileCnt}, {16'd1, 16'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
